pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
Fetch-stage controller that sequences the program counter. It merges the ID jump and EX branch redirect requests, stalls the PC for load-use hazards and instruction-memory wait states, and holds a redirect arriving during a wait until it can be applied. It also generates the IF/ID flush and stall controls. It sits between the ID/EX/hazard logic and the PC register: PC_Redirect/PC_Redirect_dest drive the PC's branch inputs, and the PC's jump input is tied 0.

Parameters:
ADDR_WIDTH, 32, width of PC and redirect destinations
CNT_WIDTH, 32, width of the performance counters

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ID_Jump  in  1  jump resolved in ID this cycle
ID_PC_dest  in  ADDR_WIDTH  jump target
EX_PC_Branch  in  1  taken branch resolved in EX this cycle
EX_PC_Branch_dest  in  ADDR_WIDTH  branch target
ID_LoadUse  in  1  load-use hazard detected on the instruction in ID
IMEM_Ready  in  1  instruction memory returns valid data this cycle
PC_Stall  out  1  hold PC
PC_Redirect  out  1  load PC_Redirect_dest at next edge
PC_Redirect_dest  out  ADDR_WIDTH  redirect target
IF_Flush  out  1  squash IF/ID register
ID_Flush  out  1  squash ID/EX register
ID_Stall  out  1  hold IF/ID register
Stall_Count  out  CNT_WIDTH  cycles with PC_Stall=1, saturating
Redirect_Count  out  CNT_WIDTH  redirects applied, saturating

Behaviour:
- States: RUN, WAIT_MEM, PEND_REDIR. Registers: state, pend_dest, pend_is_branch, both counters.
- Outputs are combinational from state and inputs. PC acts at the next edge, so latency is 0 cycles from request to PC load.
- Reset: state=RUN, pend_dest=0, counters=0. All control outputs=0 when inputs are 0. Reset mid-operation discards any pending redirect.
- Invariant: PC_Redirect and PC_Stall are never both 1. The PC gives stall priority, so a redirect issued during a stall would be lost.
- Redirect priority: EX_PC_Branch over ID_Jump. With both asserted, the branch target is used and the jump is dropped (it is on the wrong path).
- Flush on a branch: IF_Flush=1 and ID_Flush=1 for 1 cycle.
- Flush on a jump: IF_Flush=1 only.
- RUN, IMEM_Ready=1:
  - Branch: PC_Redirect=1, dest=EX_PC_Branch_dest, flushes as above. Overrides ID_LoadUse (the hazard instruction is squashed).
  - Else ID_LoadUse: PC_Stall=1, ID_Stall=1, ID_Flush=1 (bubble). Any ID_Jump is suppressed; the jump re-asserts next cycle.
  - Else jump: PC_Redirect=1, dest=ID_PC_dest, IF_Flush=1.
  - Else: all outputs 0 (PC increments).
- RUN, IMEM_Ready=0: PC_Stall=1, ID_Stall=1, go WAIT_MEM.
  - If a redirect is also requested (priority as above), latch its dest and type into pend_*, assert its flushes this cycle, and go PEND_REDIR instead.
- WAIT_MEM:
  - PC_Stall=1 and ID_Stall=1 while IMEM_Ready=0.
  - A redirect arriving here is latched, its flushes asserted, and the state moves to PEND_REDIR.
  - On IMEM_Ready=1, evaluate exactly as RUN in the same cycle, then go RUN.
- PEND_REDIR:
  - PC_Stall=1 while IMEM_Ready=0.
  - A new EX_PC_Branch overwrites pend_dest. A new ID_Jump is ignored if pend_is_branch=1, otherwise it overwrites.
  - On IMEM_Ready=1: PC_Redirect=1, dest=pend_dest, IF_Flush=1 (the fetched word is wrong-path), go RUN. Same-cycle ID/EX requests are ignored.
- ID_Flush during a hazard bubble takes precedence over ID_Stall on the ID/EX register; ID_Stall applies only to IF/ID.
- Stall_Count increments in every cycle with PC_Stall=1. Redirect_Count increments in every cycle with PC_Redirect=1. Both saturate at all-ones; there is no wrap.

Test Plan:
- Reset=1 for 2 cycles with ID_Jump=1 and IMEM_Ready=0 -> all control outputs 0, counters 0, state RUN after release.
- RUN, EX_PC_Branch=1 dest 0x40 and ID_Jump=1 dest 0x80 in the same cycle -> PC_Redirect=1, dest 0x40, IF_Flush=1, ID_Flush=1, Redirect_Count=1.
- ID_LoadUse=1 with ID_Jump=1 dest 0x20 for 1 cycle, then jump alone -> cycle 1: PC_Stall=1, ID_Flush=1, PC_Redirect=0. Cycle 2: PC_Redirect=1, dest 0x20.
- IMEM_Ready=0 for 3 cycles, EX_PC_Branch dest 0x100 in cycle 2 -> PC_Stall=1 for cycles 1-3, flushes in cycle 2. Cycle 4 with Ready=1: PC_Redirect=1, dest 0x100, PC_Stall=0. Stall_Count=3.
- PEND_REDIR holding a jump to 0x30, then EX_PC_Branch dest 0x50 while Ready=0, then a second jump to 0x70 -> the redirect on Ready=1 uses 0x50.
- Stall_Count preset near saturation (CNT_WIDTH=4 build), 20 stall cycles -> Stall_Count holds at 0xF.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer.
// Merges the EX branch and ID jump redirects, stalls the PC for load-use
// hazards and instruction-memory wait states, and parks a redirect that
// arrives during a wait until the memory can accept it. It also drives the
// IF/ID and ID/EX flush/stall controls and two saturating performance counters.
module pc_redirect_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  ID_Jump,
   input  logic [ADDR_WIDTH-1:0] ID_PC_dest,
   input  logic                  EX_PC_Branch,
   input  logic [ADDR_WIDTH-1:0] EX_PC_Branch_dest,
   input  logic                  ID_LoadUse,
   input  logic                  IMEM_Ready,
   output logic                  PC_Stall,
   output logic                  PC_Redirect,
   output logic [ADDR_WIDTH-1:0] PC_Redirect_dest,
   output logic                  IF_Flush,
   output logic                  ID_Flush,
   output logic                  ID_Stall,
   output logic [CNT_WIDTH-1:0]  Stall_Count,
   output logic [CNT_WIDTH-1:0]  Redirect_Count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_MEM   = 2'd1,
      PEND_REDIR = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pend_dest_q, pend_dest_d;
   logic                    pend_is_branch_q, pend_is_branch_d;
   logic [CNT_WIDTH-1:0]    stall_cnt_q, redir_cnt_q;

   // A jump seen alongside a load-use hazard belongs to the stalled
   // instruction; it reasserts once the bubble has been inserted.
   logic                    jump_ok;
   assign jump_ok = ID_Jump & ~ID_LoadUse;

   // Control outputs and next state, combinational from state and requests.
   always_comb begin
      PC_Stall         = 1'b0;
      PC_Redirect      = 1'b0;
      PC_Redirect_dest = '0;
      IF_Flush         = 1'b0;
      ID_Flush         = 1'b0;
      ID_Stall         = 1'b0;
      state_d          = state_q;
      pend_dest_d      = pend_dest_q;
      pend_is_branch_d = pend_is_branch_q;

      if (!Reset) begin
         unique case (state_q)
            // WAIT_MEM behaves as RUN: once the memory is ready the normal
            // rules apply in the same cycle; while it is not, a redirect is
            // parked so it is not lost behind the stall.
            RUN, WAIT_MEM: begin
               if (IMEM_Ready) begin
                  state_d = RUN;
                  if (EX_PC_Branch) begin
                     // Branch squashes everything younger, including a
                     // load-use victim and any wrong-path jump in ID.
                     PC_Redirect      = 1'b1;
                     PC_Redirect_dest = EX_PC_Branch_dest;
                     IF_Flush         = 1'b1;
                     ID_Flush         = 1'b1;
                  end else if (ID_LoadUse) begin
                     // Hold PC and IF/ID, inject a bubble into ID/EX.
                     PC_Stall = 1'b1;
                     ID_Stall = 1'b1;
                     ID_Flush = 1'b1;
                  end else if (ID_Jump) begin
                     PC_Redirect      = 1'b1;
                     PC_Redirect_dest = ID_PC_dest;
                     IF_Flush         = 1'b1;
                  end
               end else begin
                  PC_Stall = 1'b1;
                  ID_Stall = 1'b1;
                  if (EX_PC_Branch) begin
                     IF_Flush         = 1'b1;
                     ID_Flush         = 1'b1;
                     pend_dest_d      = EX_PC_Branch_dest;
                     pend_is_branch_d = 1'b1;
                     state_d          = PEND_REDIR;
                  end else if (jump_ok) begin
                     IF_Flush         = 1'b1;
                     pend_dest_d      = ID_PC_dest;
                     pend_is_branch_d = 1'b0;
                     state_d          = PEND_REDIR;
                  end else begin
                     state_d = WAIT_MEM;
                  end
               end
            end

            // A redirect is parked; apply it as soon as the memory is ready.
            PEND_REDIR: begin
               if (IMEM_Ready) begin
                  // The word fetched this cycle is wrong-path.
                  PC_Redirect      = 1'b1;
                  PC_Redirect_dest = pend_dest_q;
                  IF_Flush         = 1'b1;
                  state_d          = RUN;
               end else begin
                  PC_Stall = 1'b1;
                  if (EX_PC_Branch) begin
                     pend_dest_d      = EX_PC_Branch_dest;
                     pend_is_branch_d = 1'b1;
                  end else if (ID_Jump && !pend_is_branch_q) begin
                     // A jump cannot displace a branch: it would be on the
                     // branch's wrong path.
                     pend_dest_d = ID_PC_dest;
                  end
               end
            end

            default: state_d = RUN;
         endcase
      end
   end

   // State, parked redirect and saturating counters.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q          <= RUN;
         pend_dest_q      <= '0;
         pend_is_branch_q <= 1'b0;
         stall_cnt_q      <= '0;
         redir_cnt_q      <= '0;
      end else begin
         state_q          <= state_d;
         pend_dest_q      <= pend_dest_d;
         pend_is_branch_q <= pend_is_branch_d;
         if (PC_Stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (PC_Redirect && (redir_cnt_q != {CNT_WIDTH{1'b1}})) begin
            redir_cnt_q <= redir_cnt_q + CNT_ONE;
         end
      end
   end

   assign Stall_Count    = stall_cnt_q;
   assign Redirect_Count = redir_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table, randomized run against a
// pending-redirect reference model, and a counter saturation run on a
// narrow-counter instance.
module tb_pc_redirect_ctrl;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset, ID_Jump, EX_PC_Branch, ID_LoadUse, IMEM_Ready;
   logic [31:0] ID_PC_dest, EX_PC_Branch_dest;
   logic        PC_Stall, PC_Redirect, IF_Flush, ID_Flush, ID_Stall;
   logic [31:0] PC_Redirect_dest, Stall_Count, Redirect_Count;

   // narrow-counter instance signals
   logic        s_Reset, s_Ready, s_Zero;
   logic [31:0] s_Zdest;
   logic        s_Stall, s_Redir, s_IFF, s_IDF, s_IDS;
   logic [31:0] s_Dest;
   logic [3:0]  s_Scnt, s_Rcnt;

   pc_redirect_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .ID_Jump(ID_Jump), .ID_PC_dest(ID_PC_dest),
      .EX_PC_Branch(EX_PC_Branch), .EX_PC_Branch_dest(EX_PC_Branch_dest),
      .ID_LoadUse(ID_LoadUse), .IMEM_Ready(IMEM_Ready),
      .PC_Stall(PC_Stall), .PC_Redirect(PC_Redirect),
      .PC_Redirect_dest(PC_Redirect_dest),
      .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .ID_Stall(ID_Stall),
      .Stall_Count(Stall_Count), .Redirect_Count(Redirect_Count)
   );

   pc_redirect_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) u_sat (
      .Clk(Clk), .Reset(s_Reset),
      .ID_Jump(s_Zero), .ID_PC_dest(s_Zdest),
      .EX_PC_Branch(s_Zero), .EX_PC_Branch_dest(s_Zdest),
      .ID_LoadUse(s_Zero), .IMEM_Ready(s_Ready),
      .PC_Stall(s_Stall), .PC_Redirect(s_Redir),
      .PC_Redirect_dest(s_Dest),
      .IF_Flush(s_IFF), .ID_Flush(s_IDF), .ID_Stall(s_IDS),
      .Stall_Count(s_Scnt), .Redirect_Count(s_Rcnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // in  bits: {rst, jmp, br, lu, rdy}
   // out bits: {stall, redir, if_flush, id_flush, id_stall}
   typedef struct {
      logic [4:0]  in_bits;
      logic [31:0] jd;
      logic [31:0] bd;
      logic [4:0]  exp_bits;
      logic [31:0] exp_dest;
      int          exp_sc;
      int          exp_rc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [4:0] i, input logic [31:0] jd, input logic [31:0] bd,
                      input logic [4:0] e, input logic [31:0] ed, input int sc, input int rc);
      vec_t v;
      v.in_bits = i; v.jd = jd; v.bd = bd;
      v.exp_bits = e; v.exp_dest = ed; v.exp_sc = sc; v.exp_rc = rc;
      vecs.push_back(v);
   endtask

   function automatic logic [4:0] out_bits();
      return {PC_Stall, PC_Redirect, IF_Flush, ID_Flush, ID_Stall};
   endfunction

   // reference model: only the parked redirect and the counters matter
   logic        m_pend, m_pbr;
   logic [31:0] m_pdest;
   longint      m_sc, m_rc;

   initial begin
      s_Reset = 1'b1; s_Ready = 1'b1; s_Zero = 1'b0; s_Zdest = 32'h0;

      // reset, priority, load-use, wait with branch, pending overwrite, mid-op reset
      add(5'b11000, 32'h0,  32'h0,   5'b00000, 32'h0,   0, 0);
      add(5'b11000, 32'h0,  32'h0,   5'b00000, 32'h0,   0, 0);
      add(5'b00001, 32'h0,  32'h0,   5'b00000, 32'h0,   0, 0);
      add(5'b01101, 32'h80, 32'h40,  5'b01110, 32'h40,  0, 0);
      add(5'b01011, 32'h20, 32'h0,   5'b10011, 32'h0,   0, 1);
      add(5'b01001, 32'h20, 32'h0,   5'b01100, 32'h20,  1, 1);
      add(5'b00000, 32'h0,  32'h0,   5'b10001, 32'h0,   1, 2);
      add(5'b00100, 32'h0,  32'h100, 5'b10111, 32'h0,   2, 2);
      add(5'b00000, 32'h0,  32'h0,   5'b10000, 32'h0,   3, 2);
      add(5'b00001, 32'h0,  32'h0,   5'b01100, 32'h100, 4, 2);
      add(5'b00001, 32'h0,  32'h0,   5'b00000, 32'h0,   4, 3);
      add(5'b01000, 32'h30, 32'h0,   5'b10101, 32'h0,   4, 3);
      add(5'b00100, 32'h0,  32'h50,  5'b10000, 32'h0,   5, 3);
      add(5'b01000, 32'h70, 32'h0,   5'b10000, 32'h0,   6, 3);
      add(5'b01101, 32'h90, 32'hA0,  5'b01100, 32'h50,  7, 3);
      add(5'b00001, 32'h0,  32'h0,   5'b00000, 32'h0,   7, 4);
      add(5'b01000, 32'h60, 32'h0,   5'b10101, 32'h0,   7, 4);
      add(5'b11000, 32'h60, 32'h0,   5'b00000, 32'h0,   8, 4);
      add(5'b00001, 32'h0,  32'h0,   5'b00000, 32'h0,   0, 0);
      add(5'b01001, 32'h44, 32'h0,   5'b01100, 32'h44,  0, 0);

      foreach (vecs[k]) begin
         {Reset, ID_Jump, EX_PC_Branch, ID_LoadUse, IMEM_Ready} = vecs[k].in_bits;
         ID_PC_dest = vecs[k].jd;
         EX_PC_Branch_dest = vecs[k].bd;
         @(negedge Clk);
         chk($sformatf("vec%0d ctrl", k), 32'(out_bits()), 32'(vecs[k].exp_bits));
         if (vecs[k].exp_bits[3])
            chk($sformatf("vec%0d dest", k), PC_Redirect_dest, vecs[k].exp_dest);
         chk($sformatf("vec%0d stall_cnt", k), Stall_Count, 32'(vecs[k].exp_sc));
         chk($sformatf("vec%0d redir_cnt", k), Redirect_Count, 32'(vecs[k].exp_rc));
         $display("vec %0d in=%b out=%b dest=%h sc=%0d rc=%0d", k, vecs[k].in_bits,
                  out_bits(), PC_Redirect_dest, Stall_Count, Redirect_Count);
         @(posedge Clk); #1;
      end

      // randomized run; first cycle is a reset to align the model
      m_pend = 1'b0; m_pbr = 1'b0; m_pdest = 32'h0; m_sc = 0; m_rc = 0;
      for (int n = 0; n < 1500; n++) begin
         logic [4:0]  e;
         logic [31:0] ed;
         logic        n_pend, n_pbr;
         logic [31:0] n_pdest;
         Reset             = (n == 0) || ($urandom_range(0, 59) == 0);
         ID_Jump           = ($urandom_range(0, 2) == 0);
         EX_PC_Branch      = ($urandom_range(0, 3) == 0);
         ID_LoadUse        = ($urandom_range(0, 4) == 0);
         IMEM_Ready        = ($urandom_range(0, 9) < 7);
         ID_PC_dest        = $urandom & 32'h0000_FFFC;
         EX_PC_Branch_dest = $urandom & 32'h0000_FFFC;

         e = 5'b0; ed = 32'h0;
         n_pend = m_pend; n_pbr = m_pbr; n_pdest = m_pdest;
         if (Reset) begin
            n_pend = 1'b0; n_pbr = 1'b0; n_pdest = 32'h0;
         end else if (m_pend) begin
            if (IMEM_Ready) begin
               e = 5'b01100; ed = m_pdest; n_pend = 1'b0;
            end else begin
               e = 5'b10000;
               if (EX_PC_Branch) begin n_pdest = EX_PC_Branch_dest; n_pbr = 1'b1; end
               else if (ID_Jump && !m_pbr) n_pdest = ID_PC_dest;
            end
         end else if (IMEM_Ready) begin
            if (EX_PC_Branch)    begin e = 5'b01110; ed = EX_PC_Branch_dest; end
            else if (ID_LoadUse) e = 5'b10011;
            else if (ID_Jump)    begin e = 5'b01100; ed = ID_PC_dest; end
         end else begin
            e = 5'b10001;
            if (EX_PC_Branch) begin
               e = 5'b10111; n_pend = 1'b1; n_pbr = 1'b1; n_pdest = EX_PC_Branch_dest;
            end else if (ID_Jump && !ID_LoadUse) begin
               e = 5'b10101; n_pend = 1'b1; n_pbr = 1'b0; n_pdest = ID_PC_dest;
            end
         end

         @(negedge Clk);
         chk($sformatf("rnd%0d ctrl", n), 32'(out_bits()), 32'(e));
         if (e[3]) chk($sformatf("rnd%0d dest", n), PC_Redirect_dest, ed);
         if (!Reset || n > 0) begin
            chk($sformatf("rnd%0d stall_cnt", n), Stall_Count, m_sc[31:0]);
            chk($sformatf("rnd%0d redir_cnt", n), Redirect_Count, m_rc[31:0]);
         end
         $display("rnd %0d in=%b out=%b exp=%b sc=%0d rc=%0d", n,
                  {Reset, ID_Jump, EX_PC_Branch, ID_LoadUse, IMEM_Ready},
                  out_bits(), e, Stall_Count, Redirect_Count);
         @(posedge Clk); #1;
         if (Reset) begin
            m_sc = 0; m_rc = 0;
         end else begin
            if (e[4]) m_sc = m_sc + 1;
            if (e[3]) m_rc = m_rc + 1;
         end
         m_pend = n_pend; m_pbr = n_pbr; m_pdest = n_pdest;
      end

      // saturation of a 4-bit stall counter over 20 stalled cycles
      Reset = 1'b0; ID_Jump = 1'b0; EX_PC_Branch = 1'b0; ID_LoadUse = 1'b0;
      s_Reset = 1'b1;
      @(posedge Clk); #1;
      s_Reset = 1'b0; s_Ready = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clk);
         chk($sformatf("sat%0d stall", c), 32'(s_Stall), 32'd1);
         @(posedge Clk); #1;
         chk($sformatf("sat%0d stall_cnt", c), 32'(s_Scnt), (c < 15) ? 32'(c) : 32'd15);
         $display("sat %0d stall_cnt=%h", c, s_Scnt);
      end
      s_Ready = 1'b1;
      @(posedge Clk); #1;
      chk("sat hold", 32'(s_Scnt), 32'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
